// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the 8-bit Wallace multiplier MAC slice.
package mult_pkg;

  localparam int MULT_W    = 8;
  localparam int MAC_LEN_W = 4;

  typedef enum logic [1:0] {
    MAC_IDLE  = 2'd0,
    MAC_ACCUM = 2'd1,
    MAC_DRAIN = 2'd2,
    MAC_DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/wallace_unsigned_multiplier_CLA_Reduced_8.sv
// Combinational 8x8 unsigned multiplier: carry-save (Wallace) reduction of the
// partial-product rows, then a 16-bit adder built from 4-bit lookahead blocks.
module wallace_unsigned_multiplier_CLA_Reduced_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 3:2 compressor on whole rows; returns {carry_row, sum_row}, truncated to 16 bits.
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj << 1, x ^ y ^ z};
  endfunction

  // Block generate/propagate of a 4-bit slice, returned as {G, P}.
  function automatic logic [1:0] gp4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] g;
    logic [3:0] pr;
    g  = x & y;
    pr = x ^ y;
    return {g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1]) | (pr[3] & pr[2] & pr[1] & g[0]),
            &pr};
  endfunction

  // 4-bit sum with fully expanded internal carries.
  function automatic logic [3:0] sum4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] pr;
    logic [3:0] c;
    g    = x & y;
    pr   = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (pr[0] & ci);
    c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & ci);
    c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0]) | (pr[2] & pr[1] & pr[0] & ci);
    return pr ^ c;
  endfunction

  logic [7:0][15:0] pp_s;
  logic [5:0][15:0] l1_s;
  logic [3:0][15:0] l2_s;
  logic [2:0][15:0] l3_s;
  logic [1:0][15:0] l4_s;
  logic [1:0]       gp0_s, gp1_s, gp2_s;
  logic             c1_s, c2_s, c3_s;

  // Shifted partial-product rows.
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = {8'b0, a & {8{b[i]}}} << i;
    end
  end

  // 8 -> 6 -> 4 -> 3 -> 2 rows; the final carry-out is dropped since the product fits 16 bits.
  assign l1_s[1:0] = csa(pp_s[0], pp_s[1], pp_s[2]);
  assign l1_s[3:2] = csa(pp_s[3], pp_s[4], pp_s[5]);
  assign l1_s[4]   = pp_s[6];
  assign l1_s[5]   = pp_s[7];
  assign l2_s[1:0] = csa(l1_s[0], l1_s[1], l1_s[2]);
  assign l2_s[3:2] = csa(l1_s[3], l1_s[4], l1_s[5]);
  assign l3_s[1:0] = csa(l2_s[0], l2_s[1], l2_s[2]);
  assign l3_s[2]   = l2_s[3];
  assign l4_s[1:0] = csa(l3_s[0], l3_s[1], l3_s[2]);

  assign gp0_s = gp4(l4_s[0][3:0],  l4_s[1][3:0]);
  assign gp1_s = gp4(l4_s[0][7:4],  l4_s[1][7:4]);
  assign gp2_s = gp4(l4_s[0][11:8], l4_s[1][11:8]);
  assign c1_s  = gp0_s[1];
  assign c2_s  = gp1_s[1] | (gp1_s[0] & gp0_s[1]);
  assign c3_s  = gp2_s[1] | (gp2_s[0] & gp1_s[1]) | (gp2_s[0] & gp1_s[0] & gp0_s[1]);

  assign p = {sum4(l4_s[0][15:12], l4_s[1][15:12], c3_s),
              sum4(l4_s[0][11:8],  l4_s[1][11:8],  c2_s),
              sum4(l4_s[0][7:4],   l4_s[1][7:4],   c1_s),
              sum4(l4_s[0][3:0],   l4_s[1][3:0],   1'b0)};

endmodule

// File: rtl/wallace_mac_8.sv
// Streaming dot-product stage: operand register -> Wallace multiplier -> product
// register -> 20-bit accumulator, with valid/ready on both sides.
module wallace_mac_8
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W,
  parameter int LEN_W = MAC_LEN_W,
  parameter int ACC_W = 2*WIDTH + LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   sum,
  output logic               busy
);

  mac_state_t         state_r, state_nxt_s;
  logic [LEN_W-1:0]   remaining_r;
  logic [WIDTH-1:0]   op_a_r, op_b_r;
  logic               op_vld_r;
  logic [2*WIDTH-1:0] mult_p_s, prod_r;
  logic               prod_vld_r;
  logic [ACC_W-1:0]   acc_r;
  logic               in_ready_r, out_valid_r, busy_r;
  logic               accept_s, start_go_s;

  assign accept_s   = in_valid & in_ready_r;
  assign start_go_s = (state_r == MAC_IDLE) & start;

  wallace_unsigned_multiplier_CLA_Reduced_8 u_mult (
    .a (op_a_r),
    .b (op_b_r),
    .p (mult_p_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MAC_IDLE: begin
        if (start) state_nxt_s = (len != '0) ? MAC_ACCUM : MAC_DONE;
        else       state_nxt_s = MAC_IDLE;
      end
      MAC_ACCUM: begin
        if (accept_s && (remaining_r == LEN_W'(1))) state_nxt_s = MAC_DRAIN;
        else                                         state_nxt_s = MAC_ACCUM;
      end
      // The last product is in prod_r with nothing behind it: it lands in acc this edge.
      MAC_DRAIN: begin
        if (!op_vld_r && prod_vld_r) state_nxt_s = MAC_DONE;
        else                         state_nxt_s = MAC_DRAIN;
      end
      MAC_DONE: begin
        if (out_valid_r && out_ready) state_nxt_s = MAC_IDLE;
        else                          state_nxt_s = MAC_DONE;
      end
      default: state_nxt_s = MAC_IDLE;
    endcase
  end

  // FSM state, registered status outputs and pair countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= MAC_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      remaining_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == MAC_ACCUM);
      out_valid_r <= (state_nxt_s == MAC_DONE);
      busy_r      <= (state_nxt_s != MAC_IDLE);
      if (start_go_s)    remaining_r <= len;
      else if (accept_s) remaining_r <= remaining_r - LEN_W'(1);
      else               remaining_r <= remaining_r;
    end
  end

  // Operand/product pipeline and accumulator; runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r     <= '0;
      op_b_r     <= '0;
      op_vld_r   <= 1'b0;
      prod_r     <= '0;
      prod_vld_r <= 1'b0;
      acc_r      <= '0;
    end else begin
      if (accept_s) begin
        op_a_r   <= a;
        op_b_r   <= b;
        op_vld_r <= 1'b1;
      end else begin
        op_vld_r <= 1'b0;
      end
      prod_r     <= mult_p_s;
      prod_vld_r <= op_vld_r;
      if (start_go_s)      acc_r <= '0;
      else if (prod_vld_r) acc_r <= acc_r + {{(ACC_W-2*WIDTH){1'b0}}, prod_r};
      else                 acc_r <= acc_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = acc_r;

endmodule

// File: tb/tb_wallace_mac_8.sv
// Directed, table-driven bench for wallace_mac_8 with hand-computed dot products.
module tb_wallace_mac_8;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [3:0]  len;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [19:0] sum;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  wallace_mac_8 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  typedef struct packed {
    logic [3:0]       len;
    logic [3:0]       gap;   // idle in_valid cycles after the first pair
    logic [3:0]       hold;  // cycles of out_ready=0 while out_valid is high
    logic             ign;   // pulse start during ACCUM and DONE
    logic [14:0][7:0] va;
    logic [14:0][7:0] vb;
    logic [19:0]      exp_sum;
  } job_t;

  job_t jobs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    start = 1'b1; len = j.len; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    start = 1'b0;
    if (j.len != 4'd0) begin
      chk("in_ready_after_start", 32'(in_ready), 32'd1);
      for (int i = 0; i < int'(j.len); i++) begin
        in_valid = 1'b1; a = j.va[i]; b = j.vb[i];
        tick;
        if (i == 0 && j.len > 4'd1) begin
          in_valid = 1'b0;
          for (int g = 0; g < int'(j.gap); g++) begin
            if (j.ign && g == 0) begin start = 1'b1; len = 4'd9; end
            tick;
            start = 1'b0;
            chk("in_ready_in_gap", 32'(in_ready), 32'd1);
            chk("busy_in_gap", 32'(busy), 32'd1);
          end
        end
      end
      in_valid = 1'b0;
      chk("in_ready_drain", 32'(in_ready), 32'd0);
      chk("out_valid_k0", 32'(out_valid), 32'd0);
      tick;
      chk("out_valid_k1", 32'(out_valid), 32'd0);
      tick;
    end else begin
      chk("in_ready_len0", 32'(in_ready), 32'd0);
    end
    chk("out_valid_rise", 32'(out_valid), 32'd1);
    chk("sum", 32'(sum), 32'(j.exp_sum));
    for (int h = 0; h < int'(j.hold); h++) begin
      if (j.ign) begin start = 1'b1; len = 4'd0; end
      tick;
      chk("out_valid_held", 32'(out_valid), 32'd1);
      chk("sum_held", 32'(sum), 32'(j.exp_sum));
      chk("in_ready_done", 32'(in_ready), 32'd0);
    end
    start = j.ign; out_ready = 1'b1;
    tick;
    start = 1'b0; out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("busy_after_hs", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'd0; b = 8'd0;

    for (int i = 0; i < 6; i++) jobs[i] = '0;
    jobs[0].len = 4'd3; jobs[0].exp_sum = 20'd37718;
    jobs[0].va[0] = 8'd98;  jobs[0].vb[0] = 8'd115;
    jobs[0].va[1] = 8'd170; jobs[0].vb[1] = 8'd99;
    jobs[0].va[2] = 8'd229; jobs[0].vb[2] = 8'd42;
    jobs[1].len = 4'd15; jobs[1].exp_sum = 20'd975375;
    for (int i = 0; i < 15; i++) begin jobs[1].va[i] = 8'd255; jobs[1].vb[i] = 8'd255; end
    jobs[2].len = 4'd0; jobs[2].exp_sum = 20'd0;
    jobs[3].len = 4'd2; jobs[3].gap = 4'd4; jobs[3].hold = 4'd5; jobs[3].exp_sum = 20'd221;
    jobs[3].va[0] = 8'd10; jobs[3].vb[0] = 8'd20;
    jobs[3].va[1] = 8'd3;  jobs[3].vb[1] = 8'd7;
    jobs[4].len = 4'd4; jobs[4].exp_sum = 20'd512;
    jobs[4].va[0] = 8'd1;   jobs[4].vb[0] = 8'd1;
    jobs[4].va[1] = 8'd0;   jobs[4].vb[1] = 8'd200;
    jobs[4].va[2] = 8'd255; jobs[4].vb[2] = 8'd1;
    jobs[4].va[3] = 8'd16;  jobs[4].vb[3] = 8'd16;
    jobs[5].len = 4'd3; jobs[5].gap = 4'd1; jobs[5].hold = 4'd2; jobs[5].ign = 1'b1;
    jobs[5].exp_sum = 20'd68;
    jobs[5].va[0] = 8'd2; jobs[5].vb[0] = 8'd3;
    jobs[5].va[1] = 8'd4; jobs[5].vb[1] = 8'd5;
    jobs[5].va[2] = 8'd6; jobs[5].vb[2] = 8'd7;

    tick; tick;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    tick;

    for (int n = 0; n < 6; n++) run_job(jobs[n]);

    // Abort a len=5 job after two accepts, then run a fresh single-pair job.
    start = 1'b1; len = 4'd5;
    tick;
    start = 1'b0;
    in_valid = 1'b1; a = 8'd200; b = 8'd200;
    tick;
    a = 8'd100; b = 8'd100;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    tick;
    chk("midrst_sum_held", 32'(sum), 32'd0);
    rst = 1'b0;
    tick;
    jobs[0] = '0;
    jobs[0].len = 4'd1; jobs[0].exp_sum = 20'd144;
    jobs[0].va[0] = 8'd12; jobs[0].vb[0] = 8'd12;
    run_job(jobs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
